mem_ctrl: RTL and testbench

Byte-serial memory controller; the responder end of the instruction-fetch interface. It accepts word fetch requests (asking/addr) from the instruction cache and returns assembled 32-bit words with a one-cycle data_ready pulse. It also serves load/store requests from the LSB and arbitrates both onto a single byte-wide synchronous RAM port.

---
 rtl/mem_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// mem_ctrl : byte-serial RAM controller arbitrating instruction fetches and
//            LSB loads/stores onto a single byte-wide synchronous RAM port.
// Revision : 1.0
// ============================================================================
module mem_ctrl #(
   parameter int RD_LAT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ic_asking,
   input  logic [31:0] ic_addr,
   input  logic        ic_flush,
   output logic [31:0] ic_data,
   output logic        ic_data_ready,
   input  logic        lsb_valid,
   input  logic        lsb_wr,
   input  logic [31:0] lsb_addr,
   input  logic [1:0]  lsb_size,
   input  logic        lsb_signed,
   input  logic [31:0] lsb_wdata,
   output logic [31:0] lsb_rdata,
   output logic        lsb_done,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr
);
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [2:0] c_lat = 3'(RD_LAT);

   state_t      state_q, state_d;
   logic        is_fetch_q, is_fetch_d;
   logic        sgn_q, sgn_d;
   logic [2:0]  n_q, n_d;
   logic [2:0]  cyc_q, cyc_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] buf_q, buf_d;
   logic        ic_pend_q, ic_pend_d;
   logic [31:0] ic_addr_q, ic_addr_d;
   logic [31:0] ic_data_q, ic_data_d;
   logic        ic_data_ready_q, ic_data_ready_d;
   logic [31:0] lsb_rdata_q, lsb_rdata_d;
   logic        lsb_done_q, lsb_done_d;
   logic [31:0] mem_a_q, mem_a_d;
   logic [7:0]  mem_dout_q, mem_dout_d;
   logic        mem_wr_q, mem_wr_d;

   logic        w_start_lsb, w_fetch_req, w_start_fetch;
   logic [2:0]  w_idx, w_lsb_n;
   logic [31:0] w_ext;

   always_comb begin
      state_d         = state_q;
      is_fetch_d      = is_fetch_q;
      sgn_d           = sgn_q;
      n_d             = n_q;
      cyc_d           = cyc_q;
      addr_d          = addr_q;
      wdata_d         = wdata_q;
      buf_d           = buf_q;
      ic_pend_d       = ic_pend_q;
      ic_addr_d       = ic_addr_q;
      ic_data_d       = ic_data_q;
      ic_data_ready_d = 1'b0;
      lsb_rdata_d     = lsb_rdata_q;
      lsb_done_d      = 1'b0;
      mem_a_d         = mem_a_q;
      mem_dout_d      = mem_dout_q;
      mem_wr_d        = mem_wr_q;
      w_ext           = '0;

      w_idx   = cyc_q - c_lat - 3'd1;
      w_lsb_n = (lsb_size == 2'b00) ? 3'd1 : (lsb_size == 2'b01) ? 3'd2 : 3'd4;

      // A completing fetch consumes its own pending flag; only a fresh ask counts.
      w_start_lsb   = (state_q == S_IDLE) && lsb_valid;
      w_fetch_req   = !ic_flush &&
                      (ic_asking || (ic_pend_q && !(state_q == S_DONE && is_fetch_q)));
      w_start_fetch = (state_q == S_IDLE || state_q == S_DONE) && !w_start_lsb && w_fetch_req;

      if (ic_flush) begin
         ic_pend_d = 1'b0;
      end else if (ic_asking) begin
         ic_pend_d = 1'b1;
         ic_addr_d = ic_addr;
      end else if (state_q == S_DONE && is_fetch_q) begin
         ic_pend_d = 1'b0;
      end

      case (state_q)
         S_READ: begin
            if (is_fetch_q && ic_flush) begin
               state_d = S_IDLE;
               mem_a_d = '0;
            end else begin
               cyc_d   = cyc_q + 3'd1;
               mem_a_d = (cyc_q < n_q) ? addr_q + {29'd0, cyc_q} : '0;
               if (cyc_q > c_lat && w_idx < n_q) begin
                  buf_d[{w_idx[1:0], 3'b000} +: 8] = mem_din;
               end
               if (cyc_q == n_q + c_lat) begin
                  state_d = S_DONE;
                  w_ext   = buf_d;
                  if (sgn_q && n_q == 3'd1 && buf_d[7])  w_ext[31:8]  = '1;
                  if (sgn_q && n_q == 3'd2 && buf_d[15]) w_ext[31:16] = '1;
                  if (is_fetch_q) begin
                     ic_data_d       = buf_d;
                     ic_data_ready_d = 1'b1;
                  end else begin
                     lsb_rdata_d = w_ext;
                     lsb_done_d  = 1'b1;
                  end
               end
            end
         end
         S_WRITE: begin
            if (cyc_q < n_q) begin
               mem_a_d    = addr_q + {29'd0, cyc_q};
               mem_dout_d = wdata_q[{cyc_q[1:0], 3'b000} +: 8];
               mem_wr_d   = 1'b1;
               cyc_d      = cyc_q + 3'd1;
            end else begin
               state_d    = S_DONE;
               lsb_done_d = 1'b1;
               mem_a_d    = '0;
               mem_dout_d = '0;
               mem_wr_d   = 1'b0;
            end
         end
         default: begin
            state_d    = S_IDLE;
            mem_a_d    = '0;
            mem_dout_d = '0;
            mem_wr_d   = 1'b0;
            if (w_start_lsb) begin
               is_fetch_d = 1'b0;
               addr_d     = lsb_addr;
               n_d        = w_lsb_n;
               sgn_d      = lsb_signed;
               wdata_d    = lsb_wdata;
               cyc_d      = 3'd1;
               buf_d      = '0;
               mem_a_d    = lsb_addr;
               if (lsb_wr) begin
                  state_d    = S_WRITE;
                  mem_wr_d   = 1'b1;
                  mem_dout_d = lsb_wdata[7:0];
               end else begin
                  state_d = S_READ;
               end
            end else if (w_start_fetch) begin
               is_fetch_d = 1'b1;
               addr_d     = ic_asking ? ic_addr : ic_addr_q;
               mem_a_d    = ic_asking ? ic_addr : ic_addr_q;
               n_d        = 3'd4;
               sgn_d      = 1'b0;
               cyc_d      = 3'd1;
               buf_d      = '0;
               state_d    = S_READ;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= S_IDLE;
         is_fetch_q      <= 1'b0;
         sgn_q           <= 1'b0;
         n_q             <= '0;
         cyc_q           <= '0;
         addr_q          <= '0;
         wdata_q         <= '0;
         buf_q           <= '0;
         ic_pend_q       <= 1'b0;
         ic_addr_q       <= '0;
         ic_data_q       <= '0;
         ic_data_ready_q <= 1'b0;
         lsb_rdata_q     <= '0;
         lsb_done_q      <= 1'b0;
         mem_a_q         <= '0;
         mem_dout_q      <= '0;
         mem_wr_q        <= 1'b0;
      end else begin
         state_q         <= state_d;
         is_fetch_q      <= is_fetch_d;
         sgn_q           <= sgn_d;
         n_q             <= n_d;
         cyc_q           <= cyc_d;
         addr_q          <= addr_d;
         wdata_q         <= wdata_d;
         buf_q           <= buf_d;
         ic_pend_q       <= ic_pend_d;
         ic_addr_q       <= ic_addr_d;
         ic_data_q       <= ic_data_d;
         ic_data_ready_q <= ic_data_ready_d;
         lsb_rdata_q     <= lsb_rdata_d;
         lsb_done_q      <= lsb_done_d;
         mem_a_q         <= mem_a_d;
         mem_dout_q      <= mem_dout_d;
         mem_wr_q        <= mem_wr_d;
      end
   end

   assign ic_data       = ic_data_q;
   assign ic_data_ready = ic_data_ready_q;
   assign lsb_rdata     = lsb_rdata_q;
   assign lsb_done      = lsb_done_q;
   assign mem_a         = mem_a_q;
   assign mem_dout      = mem_dout_q;
   assign mem_wr        = mem_wr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mem_ctrl : self-checking bench for mem_ctrl with a behavioural RAM model.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_mem_ctrl;
   localparam int RD_LAT = 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ic_asking = 1'b0, ic_flush = 1'b0;
   logic [31:0] ic_addr = '0;
   logic        lsb_valid = 1'b0, lsb_wr = 1'b0, lsb_signed = 1'b0;
   logic [31:0] lsb_addr = '0, lsb_wdata = '0;
   logic [1:0]  lsb_size = '0;
   logic [31:0] ic_data, lsb_rdata, mem_a;
   logic        ic_data_ready, lsb_done, mem_wr;
   logic [7:0]  mem_din, mem_dout;

   int checks = 0;
   int failures = 0;

   logic [7:0] ram [65536];
   logic [7:0] rd1, rd2;

   mem_ctrl #(.RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .ic_asking(ic_asking), .ic_addr(ic_addr), .ic_flush(ic_flush),
      .ic_data(ic_data), .ic_data_ready(ic_data_ready),
      .lsb_valid(lsb_valid), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_size(lsb_size),
      .lsb_signed(lsb_signed), .lsb_wdata(lsb_wdata), .lsb_rdata(lsb_rdata), .lsb_done(lsb_done),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
   );

   always #5 clk = ~clk;

   // Synchronous byte RAM: data for an address appears RD_LAT cycles later.
   always @(posedge clk) begin
      rd1 <= ram[mem_a[15:0]];
      rd2 <= rd1;
      if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
   end
   assign mem_din = (RD_LAT == 1) ? rd1 : rd2;

   function automatic int size_n(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] a, input int n, input logic sgn);
      logic [31:0] v;
      v = '0;
      for (int k = 0; k < n; k++) v = v | (32'(ram[16'(a + 32'(k))]) << (8 * k));
      if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      return v;
   endfunction

   task automatic model_trace(input logic wr, input logic [31:0] a, input int n, input logic [31:0] wd,
                              output logic [7:0][31:0] ea, output logic [7:0][7:0] ed,
                              output logic [7:0] ew);
      for (int c = 1; c <= 8; c++) begin
         ea[c-1] = (c <= n) ? a + 32'(c - 1) : '0;
         ed[c-1] = (c <= n && wr) ? 8'(wd >> (8 * (c - 1))) : '0;
         ew[c-1] = (c <= n) && wr;
      end
   endtask

   task automatic lsb_op(input logic wr, input logic [31:0] a, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] wd, output int done_cyc, output int ndone,
                         output logic [31:0] rd, output logic [7:0][31:0] addrs,
                         output logic [7:0][7:0] douts, output logic [7:0] wrs);
      @(negedge clk);
      lsb_valid = 1'b1; lsb_wr = wr; lsb_addr = a; lsb_size = sz; lsb_signed = sgn; lsb_wdata = wd;
      done_cyc = -1; ndone = 0; rd = '0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c <= 8) begin
            addrs[c-1] = mem_a; douts[c-1] = mem_dout; wrs[c-1] = mem_wr;
         end
         if (lsb_done) begin
            ndone++;
            if (done_cyc < 0) begin done_cyc = c; rd = lsb_rdata; end
            lsb_valid = 1'b0;
         end
      end
      lsb_valid = 1'b0;
   endtask

   task automatic fetch_op(input logic [31:0] a, output int rdy_cyc, output int nrdy,
                           output logic [31:0] data, output logic [7:0][31:0] addrs);
      @(negedge clk);
      ic_asking = 1'b1; ic_addr = a;
      rdy_cyc = -1; nrdy = 0; data = '0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         ic_asking = 1'b0;
         if (c <= 8) addrs[c-1] = mem_a;
         if (ic_data_ready) begin
            nrdy++;
            if (rdy_cyc < 0) begin rdy_cyc = c; data = ic_data; end
         end
      end
   endtask

   task automatic test_reset();
      lsb_valid = 1'b1; ic_asking = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({mem_a, mem_dout, mem_wr} !== 41'd0)
         begin failures++; $display("FAIL reset_mem: got a=%h d=%h w=%b expected all 0", mem_a, mem_dout, mem_wr); end
      checks++;
      if ({ic_data, ic_data_ready} !== 33'd0)
         begin failures++; $display("FAIL reset_ic: got %h/%b expected 0", ic_data, ic_data_ready); end
      checks++;
      if ({lsb_rdata, lsb_done} !== 33'd0)
         begin failures++; $display("FAIL reset_lsb: got %h/%b expected 0", lsb_rdata, lsb_done); end
      lsb_valid = 1'b0; ic_asking = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (mem_a !== 32'd0 || mem_wr !== 1'b0)
         begin failures++; $display("FAIL reset_idle: got a=%h w=%b expected 0", mem_a, mem_wr); end
   endtask

   task automatic test_fetch();
      int rc, nr; logic [31:0] d; logic [7:0][31:0] ad, ea; logic [7:0][7:0] ed; logic [7:0] ew;
      ram[16'h1000] = 8'h13; ram[16'h1001] = 8'h05; ram[16'h1002] = 8'h10; ram[16'h1003] = 8'h00;
      fetch_op(32'h1000, rc, nr, d, ad);
      model_trace(1'b0, 32'h1000, 4, '0, ea, ed, ew);
      checks++;
      if (rc != 6 || nr != 1)
         begin failures++; $display("FAIL fetch_timing: got cycle %0d count %0d expected cycle 6 count 1", rc, nr); end
      checks++;
      if (d !== 32'h0010_0513)
         begin failures++; $display("FAIL fetch_data: got %h expected 00100513", d); end
      checks++;
      if (ad !== ea)
         begin failures++; $display("FAIL fetch_addr: got %h expected %h", ad, ea); end
   endtask

   task automatic test_signed_load();
      int dc, nd; logic [31:0] rd; logic [7:0][31:0] ad; logic [7:0][7:0] dd; logic [7:0] wv;
      ram[16'h2001] = 8'h80;
      lsb_op(1'b0, 32'h2001, 2'b00, 1'b1, '0, dc, nd, rd, ad, dd, wv);
      checks++;
      if (dc != 3 || nd != 1)
         begin failures++; $display("FAIL sload_timing: got cycle %0d count %0d expected 3/1", dc, nd); end
      checks++;
      if (rd !== 32'hFFFF_FF80)
         begin failures++; $display("FAIL sload_data: got %h expected ffffff80", rd); end
      lsb_op(1'b0, 32'h2001, 2'b00, 1'b0, '0, dc, nd, rd, ad, dd, wv);
      checks++;
      if (rd !== 32'h0000_0080 || dc != 3)
         begin failures++; $display("FAIL uload_data: got %h cycle %0d expected 00000080 cycle 3", rd, dc); end
   endtask

   task automatic test_store_half();
      int dc, nd; logic [31:0] rd; logic [7:0][31:0] ad, ea; logic [7:0][7:0] dd, ed;
      logic [7:0] wv, ew; logic [7:0] keep;
      keep = ram[16'h3005];
      lsb_op(1'b1, 32'h3003, 2'b01, 1'b0, 32'hA1B2_C3D4, dc, nd, rd, ad, dd, wv);
      model_trace(1'b1, 32'h3003, 2, 32'hA1B2_C3D4, ea, ed, ew);
      checks++;
      if (dc != 3 || nd != 1)
         begin failures++; $display("FAIL shalf_timing: got cycle %0d count %0d expected 3/1", dc, nd); end
      checks++;
      if (ad !== ea || dd !== ed || wv !== ew)
         begin failures++; $display("FAIL shalf_trace: got a=%h d=%h w=%b expected a=%h d=%h w=%b", ad, dd, wv, ea, ed, ew); end
      checks++;
      if (ram[16'h3003] !== 8'hD4 || ram[16'h3004] !== 8'hC3 || ram[16'h3005] !== keep)
         begin failures++; $display("FAIL shalf_ram: got %h %h %h expected d4 c3 %h", ram[16'h3003], ram[16'h3004], ram[16'h3005], keep); end
   endtask

   task automatic test_arbitration();
      int dc, rc; logic [31:0] rd, d, a1, a8, el, ef;
      dc = -1; rc = -1; rd = '0; d = '0; a1 = '0; a8 = '0;
      el = model_load(32'h100, 4, 1'b0);
      ef = model_load(32'h0, 4, 1'b0);
      @(negedge clk);
      ic_asking = 1'b1; ic_addr = 32'h0;
      lsb_valid = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h100; lsb_size = 2'b10; lsb_signed = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         ic_asking = 1'b0;
         if (c == 1) a1 = mem_a;
         if (c == 8) a8 = mem_a;
         if (lsb_done && dc < 0) begin dc = c; rd = lsb_rdata; lsb_valid = 1'b0; end
         if (ic_data_ready && rc < 0) begin rc = c; d = ic_data; end
      end
      lsb_valid = 1'b0;
      checks++;
      if (dc != 6 || rc != 12)
         begin failures++; $display("FAIL arb_timing: got lsb %0d fetch %0d expected 6 and 12", dc, rc); end
      checks++;
      if (a1 !== 32'h100 || a8 !== 32'h1)
         begin failures++; $display("FAIL arb_order: got c1=%h c8=%h expected 100 and 1", a1, a8); end
      checks++;
      if (rd !== el || d !== ef)
         begin failures++; $display("FAIL arb_data: got lsb=%h ic=%h expected %h %h", rd, d, el, ef); end
   endtask

   task automatic test_flush();
      int nr, rc, nr2; logic [31:0] a3, a4, d; logic [7:0][31:0] ad;
      nr = 0; a3 = '0; a4 = '1;
      @(negedge clk);
      ic_asking = 1'b1; ic_addr = 32'h40;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         ic_asking = 1'b0;
         if (ic_data_ready) nr++;
         if (c == 3) begin a3 = mem_a; ic_flush = 1'b1; end
         if (c == 4) begin a4 = mem_a; ic_flush = 1'b0; end
      end
      checks++;
      if (nr != 0)
         begin failures++; $display("FAIL flush_ready: got %0d pulses expected 0", nr); end
      checks++;
      if (a3 !== 32'h42 || a4 !== 32'h0)
         begin failures++; $display("FAIL flush_addr: got c3=%h c4=%h expected 42 and 0", a3, a4); end
      fetch_op(32'h80, rc, nr2, d, ad);
      checks++;
      if (rc != 6 || nr2 != 1 || d !== model_load(32'h80, 4, 1'b0))
         begin failures++; $display("FAIL flush_refetch: got cycle %0d data %h expected 6 %h", rc, d, model_load(32'h80, 4, 1'b0)); end
   endtask

   task automatic test_back_to_back();
      int r1, r2; logic [31:0] d2, a7, e2;
      r1 = -1; r2 = -1; d2 = '0; a7 = '0;
      e2 = model_load(32'h2000, 4, 1'b0);
      @(negedge clk);
      ic_asking = 1'b1; ic_addr = 32'h1000;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         ic_asking = 1'b0;
         if (c == 7) a7 = mem_a;
         if (ic_data_ready) begin
            if (r1 < 0) r1 = c;
            else if (r2 < 0) begin r2 = c; d2 = ic_data; end
         end
         if (c == 6) begin ic_asking = 1'b1; ic_addr = 32'h2000; end
      end
      checks++;
      if (r1 != 6 || r2 != 12 || a7 !== 32'h2000)
         begin failures++; $display("FAIL b2b_timing: got r1=%0d r2=%0d a7=%h expected 6 12 2000", r1, r2, a7); end
      checks++;
      if (d2 !== e2)
         begin failures++; $display("FAIL b2b_data: got %h expected %h", d2, e2); end
   endtask

   task automatic test_reset_mid_store();
      logic w2; int nd, nw;
      nd = 0; nw = 0;
      @(negedge clk);
      lsb_valid = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h5000; lsb_size = 2'b10; lsb_wdata = $urandom;
      repeat (2) @(negedge clk);
      w2 = mem_wr;
      rst_n = 1'b0; lsb_valid = 1'b0;
      #1;
      checks++;
      if (w2 !== 1'b1 || mem_wr !== 1'b0)
         begin failures++; $display("FAIL rst_store_wr: got before=%b after=%b expected 1 then 0", w2, mem_wr); end
      checks++;
      if ({ic_data, ic_data_ready, lsb_rdata, lsb_done, mem_a, mem_dout, mem_wr} !== '0)
         begin failures++; $display("FAIL rst_store_outs: got %h/%h/%h expected all 0", ic_data, lsb_rdata, mem_a); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (lsb_done) nd++;
         if (mem_wr) nw++;
      end
      checks++;
      if (nd != 0 || nw != 0)
         begin failures++; $display("FAIL rst_store_after: got done=%0d writes=%0d expected 0 0", nd, nw); end
   endtask

   task automatic test_random();
      int kind, n, dc, nd; logic [31:0] a, wd, rd, exp, mask; logic [1:0] sz; logic sgn, wr;
      logic [7:0][31:0] ad, ea; logic [7:0][7:0] dd, ed; logic [7:0] wv, ew;
      for (int it = 0; it < 30; it++) begin
         kind = $urandom_range(0, 2);
         a = 32'h6000 + 32'($urandom_range(0, 63));
         if ($urandom_range(0, 5) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
         if (kind == 0) begin
            exp = model_load(a, 4, 1'b0);
            fetch_op(a, dc, nd, rd, ad);
            checks++;
            if (dc != 6 || nd != 1 || rd !== exp)
               begin failures++; $display("FAIL rnd_fetch %0d: got cycle %0d data %h expected 6 %h", it, dc, rd, exp); end
         end else begin
            wr = (kind == 2); sz = 2'($urandom_range(0, 3)); sgn = 1'($urandom); wd = $urandom;
            n = size_n(sz);
            exp = model_load(a, n, sgn);
            model_trace(wr, a, n, wd, ea, ed, ew);
            lsb_op(wr, a, sz, sgn, wd, dc, nd, rd, ad, dd, wv);
            checks++;
            if (dc != n + (wr ? 1 : 2) || nd != 1)
               begin failures++; $display("FAIL rnd_timing %0d: got cycle %0d count %0d expected %0d", it, dc, nd, n + (wr ? 1 : 2)); end
            if (!wr) begin
               checks++;
               if (rd !== exp || ad !== ea)
                  begin failures++; $display("FAIL rnd_load %0d: got %h expected %h at %h", it, rd, exp, a); end
            end else begin
               mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
               checks++;
               if (ad !== ea || dd !== ed || wv !== ew || model_load(a, n, 1'b0) !== (wd & mask))
                  begin failures++; $display("FAIL rnd_store %0d: got ram %h trace %h expected %h", it, model_load(a, n, 1'b0), ad, wd & mask); end
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) ram[i] = 8'(i ^ (i >> 8) ^ 8'h5A);
      test_reset();
      test_fetch();
      test_signed_load();
      test_store_half();
      test_arbitration();
      test_flush();
      test_back_to_back();
      test_reset_mid_store();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
`default_nettype wire
